// File: rtl/qspi_req_arbiter_if.sv
// ============================================================================
//  Module      : qspi_req_arbiter_if
//  Description : Requester (x2) and QSPI engine signal bundle for the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface qspi_req_arbiter_if;
    logic        r0_req;
    logic [1:0]  r0_op;
    logic [23:0] r0_addr;
    logic [31:0] r0_wdata;
    logic        r0_ack;
    logic        r0_done;
    logic        r0_err;
    logic [31:0] r0_rdata;

    logic        r1_req;
    logic [1:0]  r1_op;
    logic [23:0] r1_addr;
    logic [31:0] r1_wdata;
    logic        r1_ack;
    logic        r1_done;
    logic        r1_err;
    logic [31:0] r1_rdata;

    logic        eng_start;
    logic        eng_dir;
    logic        eng_erase;
    logic [23:0] eng_address;
    logic [31:0] eng_word;
    logic        eng_busy;
    logic        eng_valid;
    logic [31:0] eng_rdata;

    modport slave (
        input  r0_req, r0_op, r0_addr, r0_wdata,
        output r0_ack, r0_done, r0_err, r0_rdata,
        input  r1_req, r1_op, r1_addr, r1_wdata,
        output r1_ack, r1_done, r1_err, r1_rdata,
        output eng_start, eng_dir, eng_erase, eng_address, eng_word,
        input  eng_busy, eng_valid, eng_rdata
    );

    modport master (
        output r0_req, r0_op, r0_addr, r0_wdata,
        input  r0_ack, r0_done, r0_err, r0_rdata,
        output r1_req, r1_op, r1_addr, r1_wdata,
        input  r1_ack, r1_done, r1_err, r1_rdata,
        input  eng_start, eng_dir, eng_erase, eng_address, eng_word,
        output eng_busy, eng_valid, eng_rdata
    );
endinterface

`default_nettype wire

// File: rtl/qspi_req_arbiter.sv
// ============================================================================
//  Module      : qspi_req_arbiter
//  Description : Two-port request arbiter/sequencer with watchdog for the QSPI engine.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module qspi_req_arbiter #(
    parameter int START_HOLD = 5,
    parameter int TIMEOUT    = 24'hFFFFFF,
    parameter int ARB_MODE   = 0
) (
    input  wire logic         ACLK,
    input  wire logic         ARESET,
    qspi_req_arbiter_if.slave bus
);

    localparam logic [7:0]  c_START_HOLD = 8'(START_HOLD);
    localparam logic [23:0] c_TIMEOUT    = 24'(TIMEOUT);
    localparam logic        c_RR         = (ARB_MODE == 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  r_state;
    logic        r_owner;
    logic        r_ptr;
    logic [7:0]  r_hold;
    logic [23:0] r_wdog;
    logic        r_start;
    logic        r_dir;
    logic        r_erase;
    logic [23:0] r_addr;
    logic [31:0] r_word;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_done0;
    logic        r_done1;
    logic        r_err0;
    logic        r_err1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_any_req;
    logic        w_pick1;
    logic [1:0]  w_op;
    logic [23:0] w_addr;
    logic [31:0] w_wdata;
    logic [23:0] w_wdog_next;
    logic        w_wdog_hit;
    logic        w_valid_end;
    logic        w_drain_end;
    logic        w_is_read;

    // Port 1 wins only when port 0 is idle, or round-robin currently prefers it.
    assign w_any_req   = bus.r0_req | bus.r1_req;
    assign w_pick1     = bus.r1_req & (~bus.r0_req | (c_RR & r_ptr));
    assign w_op        = w_pick1 ? bus.r1_op    : bus.r0_op;
    assign w_addr      = w_pick1 ? bus.r1_addr  : bus.r0_addr;
    assign w_wdata     = w_pick1 ? bus.r1_wdata : bus.r0_wdata;
    assign w_wdog_next = (r_wdog == 24'hFFFFFF) ? r_wdog : r_wdog + 24'd1;
    assign w_wdog_hit  = (w_wdog_next >= c_TIMEOUT);
    assign w_valid_end = bus.eng_valid & ((r_state == S_ISSUE) | (r_state == S_WAIT));
    assign w_drain_end = (r_state == S_DRAIN) & ~bus.eng_busy;
    assign w_is_read   = ~r_dir & ~r_erase;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_hold  <= 8'd0;
            r_wdog  <= 24'd0;
            r_start <= 1'b0;
            r_dir   <= 1'b0;
            r_erase <= 1'b0;
            r_addr  <= 24'd0;
            r_word  <= 32'd0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.eng_busy && w_any_req) begin
                        r_state <= S_ISSUE;
                        r_owner <= w_pick1;
                        r_ptr   <= ~w_pick1;
                        r_ack0  <= ~w_pick1;
                        r_ack1  <= w_pick1;
                        r_start <= 1'b1;
                        r_hold  <= 8'd1;
                        r_wdog  <= 24'd0;
                        r_dir   <= w_op[0];
                        r_erase <= w_op[1];
                        r_addr  <= w_addr;
                        r_word  <= (w_op == 2'b01) ? w_wdata : 32'd0;
                    end
                end
                S_ISSUE: begin
                    r_wdog <= w_wdog_next;
                    if (bus.eng_valid) begin
                        r_start <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_wdog_hit) begin
                        r_start <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (r_hold == c_START_HOLD) begin
                        r_start <= 1'b0;
                        r_state <= S_WAIT;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                S_WAIT: begin
                    r_wdog <= w_wdog_next;
                    if (bus.eng_valid) begin
                        r_state <= S_RESP;
                    end else if (w_wdog_hit) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!bus.eng_busy) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Response path: done lands in RESP, read data only for a completed read.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            r_done0 <= (w_valid_end | w_drain_end) & ~r_owner;
            r_done1 <= (w_valid_end | w_drain_end) & r_owner;
            r_err0  <= w_drain_end & ~r_owner;
            r_err1  <= w_drain_end & r_owner;
            if (w_valid_end && w_is_read && !r_owner) begin
                r_rdata0 <= bus.eng_rdata;
            end
            if (w_valid_end && w_is_read && r_owner) begin
                r_rdata1 <= bus.eng_rdata;
            end
        end
    end

    assign bus.r0_ack      = r_ack0;
    assign bus.r1_ack      = r_ack1;
    assign bus.r0_done     = r_done0;
    assign bus.r1_done     = r_done1;
    assign bus.r0_err      = r_err0;
    assign bus.r1_err      = r_err1;
    assign bus.r0_rdata    = r_rdata0;
    assign bus.r1_rdata    = r_rdata1;
    assign bus.eng_start   = r_start;
    assign bus.eng_dir     = r_dir;
    assign bus.eng_erase   = r_erase;
    assign bus.eng_address = r_addr;
    assign bus.eng_word    = r_word;

endmodule

`default_nettype wire

// File: tb/tb_qspi_req_arbiter.sv
// ============================================================================
//  Module      : tb_qspi_req_arbiter
//  Description : Directed self-checking bench for qspi_req_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_qspi_req_arbiter;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 ACLK = ~ACLK;

    qspi_req_arbiter_if bus0 ();
    qspi_req_arbiter_if bus1 ();

    // dut0: round-robin, short watchdog; dut1: fixed priority
    qspi_req_arbiter #(.START_HOLD(5), .TIMEOUT(100), .ARB_MODE(0)) dut0 (
        .ACLK(ACLK), .ARESET(ARESET), .bus(bus0)
    );
    qspi_req_arbiter #(.START_HOLD(5), .TIMEOUT(100), .ARB_MODE(1)) dut1 (
        .ACLK(ACLK), .ARESET(ARESET), .bus(bus1)
    );

    task automatic tick;
        @(negedge ACLK);
    endtask

    task automatic idle_inputs;
        bus0.r0_req = 0; bus0.r0_op = 0; bus0.r0_addr = 0; bus0.r0_wdata = 0;
        bus0.r1_req = 0; bus0.r1_op = 0; bus0.r1_addr = 0; bus0.r1_wdata = 0;
        bus0.eng_busy = 0; bus0.eng_valid = 0; bus0.eng_rdata = 0;
        bus1.r0_req = 0; bus1.r0_op = 0; bus1.r0_addr = 0; bus1.r0_wdata = 0;
        bus1.r1_req = 0; bus1.r1_op = 0; bus1.r1_addr = 0; bus1.r1_wdata = 0;
        bus1.eng_busy = 0; bus1.eng_valid = 0; bus1.eng_rdata = 0;
    endtask

    task automatic do_reset;
        ARESET = 1; tick; tick; ARESET = 0;
    endtask

    task automatic test_reset;
        logic [8:0] ctl;
        idle_inputs();
        ARESET = 1; tick; tick;
        ctl = {bus0.r0_ack, bus0.r1_ack, bus0.r0_done, bus0.r1_done, bus0.r0_err,
               bus0.r1_err, bus0.eng_start, bus0.eng_dir, bus0.eng_erase};
        n_tests++;
        if (ctl !== 9'd0) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 9'd0); end
        n_tests++;
        if (bus0.eng_address !== 24'd0 || bus0.eng_word !== 32'd0) begin
            n_fail++; $display("FAIL reset_cmd: got %h/%h expected 0/0", bus0.eng_address, bus0.eng_word);
        end
        n_tests++;
        if (bus0.r0_rdata !== 32'd0 || bus0.r1_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus0.r0_rdata, bus0.r1_rdata);
        end
        ARESET = 0; tick;
        n_tests++;
        if (bus0.r0_ack !== 1'b0 || bus0.eng_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got ack=%b start=%b expected 0/0", bus0.r0_ack, bus0.eng_start);
        end
    endtask

    task automatic test_read;
        int starts = 1;
        bit early = 0;
        bus0.r0_req = 1; bus0.r0_op = 2'b00; bus0.r0_addr = 24'h000100;
        tick;
        n_tests++;
        if (bus0.r0_ack !== 1'b1 || bus0.eng_start !== 1'b1) begin
            n_fail++; $display("FAIL read_ack: got ack=%b start=%b expected 1/1", bus0.r0_ack, bus0.eng_start);
        end
        n_tests++;
        if ({bus0.eng_dir, bus0.eng_erase} !== 2'b00 || bus0.eng_address !== 24'h000100) begin
            n_fail++; $display("FAIL read_cmd: got dir/erase=%b addr=%h expected 00/000100",
                               {bus0.eng_dir, bus0.eng_erase}, bus0.eng_address);
        end
        bus0.r0_req = 0; bus0.eng_busy = 1;
        for (int i = 1; i < 20; i++) begin
            tick;
            if (bus0.eng_start) starts++;
            if (bus0.r0_ack || bus0.r0_done || bus0.r1_done) early = 1;
        end
        n_tests++;
        if (starts != 5) begin n_fail++; $display("FAIL read_start_len: got %0d expected 5", starts); end
        n_tests++;
        if (early) begin n_fail++; $display("FAIL read_spurious: got 1 expected 0"); end
        bus0.eng_valid = 1; bus0.eng_busy = 0; bus0.eng_rdata = 32'hDEADBEEF;
        tick;
        bus0.eng_valid = 0; bus0.eng_rdata = 0;
        n_tests++;
        if (bus0.r0_done !== 1'b1 || bus0.r0_err !== 1'b0 || bus0.r1_done !== 1'b0) begin
            n_fail++; $display("FAIL read_done: got done=%b err=%b d1=%b expected 1/0/0",
                               bus0.r0_done, bus0.r0_err, bus0.r1_done);
        end
        n_tests++;
        if (bus0.r0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_rdata: got %h expected deadbeef", bus0.r0_rdata);
        end
        tick;
        n_tests++;
        if (bus0.r0_done !== 1'b0 || bus0.r0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_done_pulse: got done=%b rdata=%h expected 0/deadbeef",
                               bus0.r0_done, bus0.r0_rdata);
        end
    endtask

    task automatic test_arbitration;
        int g0[4];
        int g1[4];
        int n0 = 0;
        int n1 = 0;
        bit both = 0;
        do_reset();
        bus0.r0_req = 1; bus0.r1_req = 1; bus1.r0_req = 1; bus1.r1_req = 1;
        for (int c = 0; c < 60 && (n0 < 4 || n1 < 4); c++) begin
            tick;
            bus0.eng_valid = 0; bus1.eng_valid = 0;
            if ((bus0.r0_ack && bus0.r1_ack) || (bus1.r0_ack && bus1.r1_ack)) both = 1;
            if ((bus0.r0_ack || bus0.r1_ack) && n0 < 4) begin
                g0[n0] = bus0.r1_ack ? 1 : 0;
                bus0.eng_valid = 1; bus0.eng_rdata = {16'hA5A5, 16'(n0)};
                n0++;
                if (n0 == 4) begin bus0.r0_req = 0; bus0.r1_req = 0; end
            end
            if ((bus1.r0_ack || bus1.r1_ack) && n1 < 4) begin
                g1[n1] = bus1.r1_ack ? 1 : 0;
                bus1.eng_valid = 1; bus1.eng_rdata = 32'h0;
                n1++;
                if (n1 == 4) begin bus1.r0_req = 0; bus1.r1_req = 0; end
            end
        end
        tick;
        bus0.eng_valid = 0; bus1.eng_valid = 0;
        tick; tick;
        n_tests++;
        if (n0 != 4 || n1 != 4) begin n_fail++; $display("FAIL arb_grants: got %0d/%0d expected 4/4", n0, n1); end
        n_tests++;
        if (both) begin n_fail++; $display("FAIL arb_dual_ack: got 1 expected 0"); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (g0[i] != (i % 2)) begin n_fail++; $display("FAIL arb_rr_%0d: got %0d expected %0d", i, g0[i], i % 2); end
            n_tests++;
            if (g1[i] != 0) begin n_fail++; $display("FAIL arb_fixed_%0d: got %0d expected 0", i, g1[i]); end
        end
        n_tests++;
        if (bus0.r0_rdata !== 32'hA5A50002 || bus0.r1_rdata !== 32'hA5A50003) begin
            n_fail++; $display("FAIL arb_rdata: got %h/%h expected a5a50002/a5a50003", bus0.r0_rdata, bus0.r1_rdata);
        end
    endtask

    task automatic test_erase;
        bit fell = 0;
        bus0.r1_req = 1; bus0.r1_op = 2'b11; bus0.r1_addr = 24'h010000; bus0.r1_wdata = 32'h55AA55AA;
        tick;
        n_tests++;
        if (bus0.r1_ack !== 1'b1 || bus0.r0_ack !== 1'b0) begin
            n_fail++; $display("FAIL erase_ack: got %b/%b expected 1/0", bus0.r1_ack, bus0.r0_ack);
        end
        n_tests++;
        if (bus0.eng_erase !== 1'b1 || bus0.eng_dir !== 1'b1 || bus0.eng_address !== 24'h010000) begin
            n_fail++; $display("FAIL erase_cmd: got erase=%b dir=%b addr=%h expected 1/1/010000",
                               bus0.eng_erase, bus0.eng_dir, bus0.eng_address);
        end
        bus0.r1_req = 0; bus0.eng_busy = 1;
        for (int c = 0; c < 20 && !fell; c++) begin
            tick;
            if (!bus0.eng_start) fell = 1;
        end
        n_tests++;
        if (!fell) begin n_fail++; $display("FAIL erase_start_drop: got 0 expected 1"); end
        tick; tick;
        bus0.eng_valid = 1; bus0.eng_busy = 0; bus0.eng_rdata = 32'hCAFEF00D;
        tick;
        bus0.eng_valid = 0;
        n_tests++;
        if (bus0.r1_done !== 1'b1 || bus0.r1_err !== 1'b0 || bus0.r0_done !== 1'b0) begin
            n_fail++; $display("FAIL erase_done: got %b/%b/%b expected 1/0/0", bus0.r1_done, bus0.r1_err, bus0.r0_done);
        end
        n_tests++;
        if (bus0.r1_rdata !== 32'hA5A50003) begin
            n_fail++; $display("FAIL erase_rdata_kept: got %h expected a5a50003", bus0.r1_rdata);
        end
        n_tests++;
        if (bus0.eng_address !== 24'h010000 || bus0.eng_erase !== 1'b1) begin
            n_fail++; $display("FAIL erase_cmd_stable: got %h/%b expected 010000/1", bus0.eng_address, bus0.eng_erase);
        end
        tick;
    endtask

    task automatic test_write_early;
        bus0.r0_req = 1; bus0.r0_op = 2'b01; bus0.r0_addr = 24'h000200; bus0.r0_wdata = 32'h12345678;
        tick;
        n_tests++;
        if (bus0.r0_ack !== 1'b1 || bus0.eng_dir !== 1'b1 || bus0.eng_erase !== 1'b0 ||
            bus0.eng_word !== 32'h12345678) begin
            n_fail++; $display("FAIL write_cmd: got ack=%b dir=%b erase=%b word=%h expected 1/1/0/12345678",
                               bus0.r0_ack, bus0.eng_dir, bus0.eng_erase, bus0.eng_word);
        end
        bus0.r0_req = 0; bus0.eng_valid = 1; bus0.eng_rdata = 32'hFFFFFFFF;
        tick;
        bus0.eng_valid = 0;
        n_tests++;
        if (bus0.eng_start !== 1'b0 || bus0.r0_done !== 1'b1) begin
            n_fail++; $display("FAIL write_early_end: got start=%b done=%b expected 0/1", bus0.eng_start, bus0.r0_done);
        end
        n_tests++;
        if (bus0.r0_rdata !== 32'hA5A50002) begin
            n_fail++; $display("FAIL write_rdata_kept: got %h expected a5a50002", bus0.r0_rdata);
        end
        tick;
    endtask

    task automatic test_timeout;
        bit bad_done = 0;
        bus0.r0_req = 1; bus0.r0_op = 2'b00; bus0.r0_addr = 24'h000300;
        tick;
        n_tests++;
        if (bus0.r0_ack !== 1'b1) begin n_fail++; $display("FAIL to_ack: got %b expected 1", bus0.r0_ack); end
        bus0.r0_req = 0; bus0.eng_busy = 1;
        for (int n = 1; n <= 150; n++) begin
            tick;
            if (n == 99) begin
                n_tests++;
                if (dut0.r_state !== 3'd2) begin n_fail++; $display("FAIL to_pre_drain: got %0d expected 2", dut0.r_state); end
            end
            if (n == 100) begin
                n_tests++;
                if (dut0.r_state !== 3'd3) begin n_fail++; $display("FAIL to_drain: got %0d expected 3", dut0.r_state); end
            end
            if (bus0.r0_done) bad_done = 1;
        end
        bus0.eng_busy = 0;
        tick;
        n_tests++;
        if (bad_done) begin n_fail++; $display("FAIL to_early_done: got 1 expected 0"); end
        n_tests++;
        if (bus0.r0_done !== 1'b1 || bus0.r0_err !== 1'b1 || bus0.r0_rdata !== 32'hA5A50002) begin
            n_fail++; $display("FAIL to_err_done: got done=%b err=%b rdata=%h expected 1/1/a5a50002",
                               bus0.r0_done, bus0.r0_err, bus0.r0_rdata);
        end
    endtask

    task automatic test_busy_hold;
        bit any_ack = 0;
        bus0.eng_busy = 1;
        bus0.r0_req = 1; bus0.r0_op = 2'b00; bus0.r1_req = 1; bus0.r1_op = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (bus0.r0_ack || bus0.r1_ack) any_ack = 1;
        end
        n_tests++;
        if (any_ack) begin n_fail++; $display("FAIL busy_no_ack: got 1 expected 0"); end
        bus0.eng_busy = 0;
        tick;
        n_tests++;
        if (bus0.r1_ack !== 1'b1 || bus0.r0_ack !== 1'b0) begin
            n_fail++; $display("FAIL busy_grant: got r0=%b r1=%b expected 0/1", bus0.r0_ack, bus0.r1_ack);
        end
        bus0.r0_req = 0; bus0.r1_req = 0; bus0.eng_valid = 1; bus0.eng_rdata = 32'h0BADF00D;
        tick;
        bus0.eng_valid = 0;
        n_tests++;
        if (bus0.r1_done !== 1'b1 || bus0.r0_done !== 1'b0) begin
            n_fail++; $display("FAIL busy_done: got r0=%b r1=%b expected 0/1", bus0.r0_done, bus0.r1_done);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [8:0] ctl;
        bit bad_done = 0;
        bus0.r0_req = 1; bus0.r0_op = 2'b00; bus0.r0_addr = 24'h000400;
        tick;
        bus0.r0_req = 0; bus0.eng_busy = 1;
        for (int i = 0; i < 8; i++) tick;
        ARESET = 1;
        tick;
        ctl = {bus0.r0_ack, bus0.r1_ack, bus0.r0_done, bus0.r1_done, bus0.r0_err,
               bus0.r1_err, bus0.eng_start, bus0.eng_dir, bus0.eng_erase};
        n_tests++;
        if (ctl !== 9'd0 || bus0.eng_address !== 24'd0 || bus0.r0_rdata !== 32'd0 || bus0.r1_rdata !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got ctl=%b addr=%h rd0=%h rd1=%h expected all 0",
                               ctl, bus0.eng_address, bus0.r0_rdata, bus0.r1_rdata);
        end
        ARESET = 0; bus0.eng_busy = 0;
        for (int i = 0; i < 10; i++) begin
            bus0.eng_valid = (i == 3);
            tick;
            if (bus0.r0_done || bus0.r1_done) bad_done = 1;
        end
        bus0.eng_valid = 0;
        n_tests++;
        if (bad_done) begin n_fail++; $display("FAIL rstmid_no_done: got 1 expected 0"); end
        bus0.r0_req = 1; bus0.r1_req = 1;
        tick;
        n_tests++;
        if (bus0.r0_ack !== 1'b1 || bus0.r1_ack !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ptr: got r0=%b r1=%b expected 1/0", bus0.r0_ack, bus0.r1_ack);
        end
        bus0.r0_req = 0; bus0.r1_req = 0; bus0.eng_valid = 1; bus0.eng_rdata = 32'h600DD00D;
        tick;
        bus0.eng_valid = 0;
        n_tests++;
        if (bus0.r0_done !== 1'b1 || bus0.r0_rdata !== 32'h600DD00D) begin
            n_fail++; $display("FAIL rstmid_resume: got done=%b rdata=%h expected 1/600dd00d", bus0.r0_done, bus0.r0_rdata);
        end
        tick;
    endtask

    initial begin
        test_reset();
        test_read();
        test_arbitration();
        test_erase();
        test_write_early();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
